seg7_capture: RTL and testbench

//  Inverse of the board's binary-to-seven-segment path: samples a multiplexed, active-low
//  7-segment bus (segments + digit enables) and recovers the displayed BCD digits.

---
 rtl/seg7_pkg.sv | 26 ++
 rtl/seg7_to_bin.sv | 29 ++
 rtl/seg7_capture.sv | 145 ++++++++++++++
 tb/tb_seg7_capture.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - segment patterns, nibble codes and FSM states for seg7_capture
package seg7_pkg;

  // Active-low patterns, bit6=g .. bit0=a
  localparam logic [6:0] SEG_0    = 7'b1000000;
  localparam logic [6:0] SEG_1    = 7'b1111001;
  localparam logic [6:0] SEG_2    = 7'b0100100;
  localparam logic [6:0] SEG_3    = 7'b0110000;
  localparam logic [6:0] SEG_4    = 7'b0011001;
  localparam logic [6:0] SEG_5    = 7'b0010010;
  localparam logic [6:0] SEG_6    = 7'b0000010;
  localparam logic [6:0] SEG_7    = 7'b1111000;
  localparam logic [6:0] SEG_8    = 7'b0000000;
  localparam logic [6:0] SEG_9    = 7'b0010000;
  localparam logic [6:0] SEG_DASH = 7'b0111111;

  localparam logic [3:0] CODE_DASH = 4'hF;
  localparam logic [3:0] CODE_BAD  = 4'hE;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seg7_to_bin.sv
// rtl/seg7_to_bin.sv - combinational active-low segment pattern to BCD nibble decoder
module seg7_to_bin
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic       illegal_o,
  output logic [3:0] nibble_o
);

  always_comb begin
    illegal_o = 1'b0;
    nibble_o  = CODE_BAD;
    case (seg_i)
      SEG_0:    nibble_o = 4'd0;
      SEG_1:    nibble_o = 4'd1;
      SEG_2:    nibble_o = 4'd2;
      SEG_3:    nibble_o = 4'd3;
      SEG_4:    nibble_o = 4'd4;
      SEG_5:    nibble_o = 4'd5;
      SEG_6:    nibble_o = 4'd6;
      SEG_7:    nibble_o = 4'd7;
      SEG_8:    nibble_o = 4'd8;
      SEG_9:    nibble_o = 4'd9;
      SEG_DASH: nibble_o = CODE_DASH;
      default:  illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_capture.sv
// rtl/seg7_capture.sv - samples a multiplexed active-low 7-segment bus and recovers the BCD digits
module seg7_capture
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4,
  parameter int TIMEOUT       = 4096
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   dig_n,
  input  logic                    capture_req,
  output logic                    busy,
  output logic                    valid,
  output logic                    err,
  output logic [4*NUM_DIGITS-1:0] value_out
);

  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT);
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_e                  state_q, state_d;
  logic [6:0]              seg_s1_q, seg_s2_q, seg_prev_q;
  logic [NUM_DIGITS-1:0]   dig_s1_q, dig_s2_q, dig_prev_q;
  logic [SW-1:0]           stable_q, stable_d;
  logic [TW-1:0]           tmo_q, tmo_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d, value_q, value_d;
  logic                    scan_err_q, scan_err_d, err_q, err_d, valid_q, valid_d;

  logic                    onehot, match, illegal;
  logic [3:0]              nibble;
  logic [IW-1:0]           idx;

  seg7_to_bin u_dec (
    .seg_i     (seg_s2_q),
    .illegal_o (illegal),
    .nibble_o  (nibble)
  );

  assign onehot = $onehot(~dig_s2_q);
  assign match  = onehot && (seg_s2_q == seg_prev_q) && (dig_s2_q == dig_prev_q);

  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!dig_s2_q[i]) idx = IW'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    stable_d   = stable_q;
    tmo_d      = tmo_q;
    seen_d     = seen_q;
    shadow_d   = shadow_q;
    scan_err_d = scan_err_q;
    value_d    = value_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (capture_req) begin
          state_d    = ST_SCAN;
          stable_d   = '0;
          tmo_d      = '0;
          seen_d     = '0;
          scan_err_d = 1'b0;
          shadow_d   = {NUM_DIGITS{CODE_BAD}};
        end
      end
      ST_SCAN: begin
        if (match) begin
          if (stable_q != SW'(STABLE_CYCLES)) stable_d = stable_q + 1'b1;
        end else begin
          stable_d = onehot ? SW'(1) : '0;
        end
        // A nonzero stable count implies the current sample is one-hot, so idx is valid.
        if (stable_d == SW'(STABLE_CYCLES) && !seen_q[idx]) begin
          shadow_d[idx*4 +: 4] = nibble;
          seen_d[idx]          = 1'b1;
          scan_err_d           = scan_err_q | illegal;
        end
        tmo_d = tmo_q + 1'b1;
        if (&seen_d) begin
          state_d = ST_DONE;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          state_d    = ST_DONE;
          scan_err_d = 1'b1;
        end
      end
      ST_DONE: begin
        value_d = shadow_q;
        err_d   = scan_err_q;
        valid_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      seg_s1_q   <= '0;
      seg_s2_q   <= '0;
      seg_prev_q <= '0;
      dig_s1_q   <= '0;
      dig_s2_q   <= '0;
      dig_prev_q <= '0;
      stable_q   <= '0;
      tmo_q      <= '0;
      seen_q     <= '0;
      shadow_q   <= '0;
      scan_err_q <= 1'b0;
      value_q    <= '0;
      err_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      seg_s1_q   <= seg_n;
      seg_s2_q   <= seg_s1_q;
      seg_prev_q <= seg_s2_q;
      dig_s1_q   <= dig_n;
      dig_s2_q   <= dig_s1_q;
      dig_prev_q <= dig_s2_q;
      stable_q   <= stable_d;
      tmo_q      <= tmo_d;
      seen_q     <= seen_d;
      shadow_q   <= shadow_d;
      scan_err_q <= scan_err_d;
      value_q    <= value_d;
      err_q      <= err_d;
      valid_q    <= valid_d;
    end
  end

  assign busy      = (state_q == ST_SCAN);
  assign valid     = valid_q;
  assign err       = err_q;
  assign value_out = value_q;

endmodule

// File: tb/tb_seg7_capture.sv
// tb/tb_seg7_capture.sv - directed self-checking bench for seg7_capture
module tb_seg7_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [6:0]  seg_n;
  logic [3:0]  dig_n;
  logic        capture_req;
  logic        busy, valid, err;
  logic [15:0] value_out;

  int total = 0;
  int bad   = 0;

  logic [6:0] pat [4];
  logic [3:0] en_mask = 4'hF;
  logic       glitch  = 1'b0;

  always #5 clk = ~clk;

  seg7_capture dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .seg_n       (seg_n),
    .dig_n       (dig_n),
    .capture_req (capture_req),
    .busy        (busy),
    .valid       (valid),
    .err         (err),
    .value_out   (value_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic pulse_req();
    @(negedge clk) capture_req = 1'b1;
    @(negedge clk) capture_req = 1'b0;
  endtask

  task automatic wait_valid(input int max, output int cyc);
    cyc = -1;
    for (int i = 1; i <= max; i++) begin
      @(posedge clk);
      #1;
      if (valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic capture(input string tag, input int max, input logic [15:0] exp_val,
                         input logic exp_err);
    int cyc;
    pulse_req();
    wait_valid(max, cyc);
    check({tag, "_valid_seen"}, 32'(cyc > 0), 32'd1);
    check({tag, "_value"}, 32'(value_out), 32'(exp_val));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    @(posedge clk);
    #1;
    check({tag, "_valid_one_cycle"}, 32'(valid), 32'd0);
  endtask

  // Round-robin display driver: 8 cycles per digit, optional glitch every 3rd cycle.
  initial begin
    logic [3:0] one;
    one   = 4'b0001;
    seg_n = 7'h7F;
    dig_n = 4'hF;
    forever begin
      for (int d = 0; d < 4; d++) begin
        for (int c = 0; c < 8; c++) begin
          @(negedge clk);
          if (!en_mask[d]) begin
            seg_n = 7'h7F;
            dig_n = 4'hF;
          end else if (glitch && (c % 3 == 2)) begin
            seg_n = pat[d];
            dig_n = ~((one << d) | (one << ((d + 1) % 4)));
          end else begin
            seg_n = pat[d];
            dig_n = ~(one << d);
          end
        end
      end
    end
  end

  initial begin
    int  cyc;
    logic saw;
    rst_n       = 1'b0;
    capture_req = 1'b0;
    pat[0] = 7'b0110000; pat[1] = 7'b1000000; pat[2] = 7'b0100100; pat[3] = 7'b1111001;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy",  32'(busy),      32'd0);
    check("rst_valid", 32'(valid),     32'd0);
    check("rst_err",   32'(err),       32'd0);
    check("rst_value", 32'(value_out), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (4) @(posedge clk);

    capture("c1", 300, 16'h1203, 1'b0);

    pat[0] = 7'b1111000; pat[1] = 7'b0100000; pat[2] = 7'b1111000; pat[3] = 7'b1111000;
    capture("c2", 300, 16'h77E7, 1'b1);

    pat[0] = 7'b0111111; pat[1] = 7'b0010000; pat[2] = 7'b0010000; pat[3] = 7'b0010000;
    capture("c3", 300, 16'h999F, 1'b0);

    pat[0] = 7'b0110000; pat[1] = 7'b1000000; pat[2] = 7'b0100100; pat[3] = 7'b1111001;
    glitch = 1'b1;
    pulse_req();
    saw = 1'b0;
    for (int i = 0; i < 160; i++) begin
      @(posedge clk);
      #1;
      if (valid || !busy) saw = 1'b1;
    end
    check("c5_no_capture_in_glitch", 32'(saw), 32'd0);
    glitch = 1'b0;
    wait_valid(300, cyc);
    check("c5_valid_seen", 32'(cyc > 0), 32'd1);
    check("c5_value", 32'(value_out), 32'h1203);
    check("c5_err", 32'(err), 32'd0);

    en_mask = 4'b0111;
    pulse_req();
    wait_valid(4200, cyc);
    check("c4_latency_window", 32'(cyc >= 4096 && cyc <= 4100), 32'd1);
    check("c4_value", 32'(value_out), 32'hE203);
    check("c4_err", 32'(err), 32'd1);
    en_mask = 4'hF;

    pulse_req();
    repeat (20) @(posedge clk);
    #1;
    check("c6_busy_before_rst", 32'(busy), 32'd1);
    @(negedge clk) rst_n = 1'b0;
    #1;
    check("c6_rst_busy",  32'(busy),      32'd0);
    check("c6_rst_value", 32'(value_out), 32'd0);
    check("c6_rst_err",   32'(err),       32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (valid || busy) saw = 1'b1;
    end
    check("c6_no_valid_after_rst", 32'(saw), 32'd0);
    capture("c6_fresh", 300, 16'h1203, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
